// File: rtl/seg_pkg.sv
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants and helpers for the 7-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    localparam int DIGIT_W = 4;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Never returns less than 1 so a degenerate count still gets a real vector
    function automatic int seg_clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg.sv
// ============================================================================
// Module      : bcd_to_seg
// Description : Combinational 4-bit code to active-low 7-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            4'd10:   o_seg = SEG_DASH;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module      : seg_scan_driver
// Description : Multiplexed common-anode 7-segment driver with prescaler,
//               double-buffered load handshake, ghost blanking, frame strobe.
//               Optional macro SEG_LEAD_ZERO_BLANK_EN blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic                          load_ready,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic                          frame_done
);

    localparam int CNT_W = seg_clog2(REFRESH_DIV);
    localparam int IDX_W = seg_clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] c_last_cnt  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] c_pre_last  = CNT_W'(REFRESH_DIV - 2);
    localparam logic [CNT_W-1:0] c_blank_end = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [CNT_W-1:0]                r_slot_cnt;
    logic [IDX_W-1:0]                r_idx;
    logic [0:0]                      r_state;
    logic [DIGIT_W*NUM_DIGITS-1:0]   r_shadow_dig;
    logic [NUM_DIGITS-1:0]           r_shadow_dp;
    logic [DIGIT_W*NUM_DIGITS-1:0]   r_disp_dig;
    logic [NUM_DIGITS-1:0]           r_disp_dp;
    logic                            r_pending;
    logic [NUM_DIGITS-1:0]           r_an;
    logic [6:0]                      r_seg;
    logic                            r_dp;
    logic                            r_frame_done;

    logic                            w_slot_end;
    logic                            w_frame_end;
    logic                            w_accept;
    logic [DIGIT_W-1:0]              w_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]           w_an_sel;
    logic [DIGIT_W-1:0]              w_code;
    logic [6:0]                      w_seg;
    logic                            w_dp_sel;

    assign w_slot_end  = (r_slot_cnt == c_last_cnt);
    assign w_frame_end = w_slot_end && (r_idx == c_last_idx);
    assign w_accept    = load && !r_pending;

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_digit[i]  = r_disp_dig[i*DIGIT_W +: DIGIT_W];
            w_an_sel[i] = (r_idx == IDX_W'(i));
        end
    end

`ifdef SEG_LEAD_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_lead_blank;
    logic                  w_run;

    // Digit 0 is never blanked so an all-zero value still reads "0"
    always_comb begin
        w_lead_blank = '0;
        w_run        = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_run           = w_run && (w_digit[i] == '0);
            w_lead_blank[i] = w_run;
        end
    end

    assign w_code = w_lead_blank[r_idx] ? 4'hF : w_digit[r_idx];
`else
    assign w_code = w_digit[r_idx];
`endif

    assign w_dp_sel = r_disp_dp[r_idx];

    bcd_to_seg u_bcd_to_seg (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot_cnt <= '0;
            r_idx      <= '0;
            r_state    <= ST_BLANK;
        end else begin
            if (w_slot_end) begin
                r_slot_cnt <= '0;
                r_idx      <= (r_idx == c_last_idx) ? '0 : r_idx + IDX_W'(1);
                r_state    <= ST_BLANK;
            end else begin
                r_slot_cnt <= r_slot_cnt + CNT_W'(1);
                if (r_slot_cnt == c_blank_end) begin
                    r_state <= ST_SHOW;
                end
            end
        end
    end

    // Accept needs !r_pending, so a load on the boundary cycle waits a frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow_dig <= '0;
            r_shadow_dp  <= '0;
            r_disp_dig   <= '0;
            r_disp_dp    <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (w_frame_end && r_pending) begin
                r_disp_dig <= r_shadow_dig;
                r_disp_dp  <= r_shadow_dp;
                r_pending  <= 1'b0;
            end
            if (w_accept) begin
                r_shadow_dig <= digits_in;
                r_shadow_dp  <= dp_in;
                r_pending    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an         <= '1;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            // Lookahead so the registered strobe lands on the boundary cycle
            r_frame_done <= (r_slot_cnt == c_pre_last) && (r_idx == c_last_idx);
            if (r_state == ST_SHOW) begin
                r_an  <= ~w_an_sel;
                r_seg <= w_seg;
                r_dp  <= ~w_dp_sel;
            end else begin
                r_an  <= '1;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end
        end
    end

    assign load_ready = ~r_pending;
    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire
